// File: rtl/lsu_stage.sv
// lsu_stage -- load/store unit pipeline stage between EXE_MEM and MEM_WB.
//
// Purpose:
//   Accepts one instruction at a time from EXE_MEM (valid/ready). Non-memory
//   instructions are passed to MEM_WB after one cycle. Loads and stores are
//   issued on a simple request/response bus. The FSM walks IDLE -> REQ -> WAIT.
//   On completion, the result is registered toward MEM_WB. For loads, the
//   byte or halfword is extracted and sign- or zero-extended.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   mem_out_valid/ready   upstream handshake (EXE_MEM -> LSU)
//   mem_in_valid/ready    downstream handshake (LSU -> MEM_WB)
//   alu_result            effective address / ALU result
//   store_data_M          store source data (rs2)
//   wdata_gpr_M           writeback data for non-load instructions
//   sram_read_write_M     00 none, 01 load, 10 store, 11 none
//   Mem_Mask_M            funct3 access size/sign
//   Gpr_*/Csr_*_M -> _W   control fields, registered toward MEM_WB
//   req_* / rsp_*         memory bus (word-aligned address, byte strobes)
//   wdata_gpr_W           final GPR writeback data
//   mem_busy              high while a bus transaction is outstanding
//   mem_fw_data           forwarding copy of wdata_gpr_W
//   misalign_err          (only with YSYX_24100006_LSU_MISALIGN_CHK_EN)
//                         flags a misaligned access completed without a bus cycle
//
// Configuration macro: YSYX_24100006_LSU_MISALIGN_CHK_EN
//   When defined, misaligned halfword/word accesses bypass the bus.
//   When undefined, misaligned accesses are issued with truncated byte lanes.

module lsu_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_out_valid,
  output logic        mem_out_ready,
  output logic        mem_in_valid,
  input  logic        mem_in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data_M,
  input  logic [31:0] wdata_gpr_M,
  input  logic [1:0]  sram_read_write_M,
  input  logic [2:0]  Mem_Mask_M,
  input  logic        Gpr_Write_M,
  input  logic [3:0]  Gpr_Write_Addr_M,
  input  logic        Csr_Write_M,
  input  logic [11:0] Csr_Write_Addr_M,
  input  logic [31:0] wdata_csr_M,
  output logic        Gpr_Write_W,
  output logic [3:0]  Gpr_Write_Addr_W,
  output logic        Csr_Write_W,
  output logic [11:0] Csr_Write_Addr_W,
  output logic [31:0] wdata_csr_W,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_wen,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] wdata_gpr_W,
  output logic        mem_busy,
  output logic [31:0] mem_fw_data
`ifdef YSYX_24100006_LSU_MISALIGN_CHK_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state;

  // Instruction latched while the bus transaction is outstanding.
  logic        pend_load;
  logic [1:0]  pend_off;
  logic [2:0]  pend_mask;
  logic [31:0] pend_wdata_gpr;
  logic        pend_gpr_write;
  logic [3:0]  pend_gpr_addr;
  logic        pend_csr_write;
  logic [11:0] pend_csr_addr;
  logic [31:0] pend_wdata_csr;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        accept;
  logic        drain;
  logic        misaligned;
  logic [1:0]  size;
  logic [1:0]  off;
  logic [3:0]  strb_base;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;
  logic [31:0] load_data;

  // Accept only when idle and the output register is empty or draining now.
  assign mem_out_ready = (state == IDLE) && (!mem_in_valid || mem_in_ready);
  assign accept        = mem_out_valid && mem_out_ready;
  assign drain         = mem_in_valid && mem_in_ready;

  assign is_load  = (sram_read_write_M == 2'b01);
  assign is_store = (sram_read_write_M == 2'b10);
  assign is_mem   = is_load || is_store;

  // funct3[1:0]: 00 byte, 01 half, 1x word.
  // This makes 011/110/111 fall into the word case.
  assign size = Mem_Mask_M[1:0];
  assign off  = alu_result[1:0];

`ifdef YSYX_24100006_LSU_MISALIGN_CHK_EN
  assign misaligned = is_mem && (((size == 2'b01) && off[0]) ||
                                 (size[1] && (off != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Byte strobes. Shifting into a 4-bit result drops lanes past byte 3.
  // A halfword at offset 3 therefore only enables lane 3.
  always_comb begin
    case (size)
      2'b00:   strb_base = 4'b0001;
      2'b01:   strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  assign lane_strb = size[1] ? 4'b1111 : (strb_base << off);

  // Store data replicated into every lane.
  // The strobes then select the lanes that are actually written.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_wdata[gi*8 +: 8] =
      (size == 2'b00) ? store_data_M[7:0] :
      (size == 2'b01) ? store_data_M[(gi % 2)*8 +: 8] :
                        store_data_M[gi*8 +: 8];
  end

  // Load extraction from the response word.
  // The upper byte of a halfword at offset 3 lies outside the word and reads as zero.
  assign rsp_byte = rsp_rdata[{pend_off, 3'b000} +: 8];

  always_comb begin
    case (pend_off)
      2'd0:    rsp_half = rsp_rdata[15:0];
      2'd1:    rsp_half = rsp_rdata[23:8];
      2'd2:    rsp_half = rsp_rdata[31:16];
      default: rsp_half = {8'h00, rsp_rdata[31:24]};
    endcase
  end

  always_comb begin
    case (pend_mask)
      3'b000:  load_data = {{24{rsp_byte[7]}}, rsp_byte};
      3'b001:  load_data = {{16{rsp_half[15]}}, rsp_half};
      3'b100:  load_data = {24'h000000, rsp_byte};
      3'b101:  load_data = {16'h0000, rsp_half};
      default: load_data = rsp_rdata;
    endcase
  end

  assign mem_busy    = (state != IDLE);
  assign mem_fw_data = wdata_gpr_W;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      mem_in_valid     <= 1'b0;
      req_valid        <= 1'b0;
      req_wen          <= 1'b0;
      req_addr         <= 32'h0;
      req_wdata        <= 32'h0;
      req_wstrb        <= 4'h0;
      wdata_gpr_W      <= 32'h0;
      Gpr_Write_W      <= 1'b0;
      Gpr_Write_Addr_W <= 4'h0;
      Csr_Write_W      <= 1'b0;
      Csr_Write_Addr_W <= 12'h0;
      wdata_csr_W      <= 32'h0;
      pend_load        <= 1'b0;
      pend_off         <= 2'b00;
      pend_mask        <= 3'b000;
      pend_wdata_gpr   <= 32'h0;
      pend_gpr_write   <= 1'b0;
      pend_gpr_addr    <= 4'h0;
      pend_csr_write   <= 1'b0;
      pend_csr_addr    <= 12'h0;
      pend_wdata_csr   <= 32'h0;
`ifdef YSYX_24100006_LSU_MISALIGN_CHK_EN
      misalign_err     <= 1'b0;
`endif
    end else begin
      // Drain first. A completion later in this block overrides it.
      // This lets a drain and a new accept happen in the same cycle.
      if (drain) begin
        mem_in_valid <= 1'b0;
`ifdef YSYX_24100006_LSU_MISALIGN_CHK_EN
        misalign_err <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mem && !misaligned) begin
              state          <= REQ;
              req_valid      <= 1'b1;
              req_wen        <= is_store;
              req_addr       <= {alu_result[31:2], 2'b00};
              req_wstrb      <= is_store ? lane_strb : 4'h0;
              req_wdata      <= is_store ? lane_wdata : 32'h0;
              pend_load      <= is_load;
              pend_off       <= off;
              pend_mask      <= Mem_Mask_M;
              pend_wdata_gpr <= wdata_gpr_M;
              pend_gpr_write <= Gpr_Write_M;
              pend_gpr_addr  <= Gpr_Write_Addr_M;
              pend_csr_write <= Csr_Write_M;
              pend_csr_addr  <= Csr_Write_Addr_M;
              pend_wdata_csr <= wdata_csr_M;
            end else begin
              // Single-cycle path: non-memory ops, and trapped misaligned ops.
              mem_in_valid     <= 1'b1;
              wdata_gpr_W      <= wdata_gpr_M;
              Gpr_Write_W      <= Gpr_Write_M && !misaligned;
              Gpr_Write_Addr_W <= Gpr_Write_Addr_M;
              Csr_Write_W      <= Csr_Write_M;
              Csr_Write_Addr_W <= Csr_Write_Addr_M;
              wdata_csr_W      <= wdata_csr_M;
`ifdef YSYX_24100006_LSU_MISALIGN_CHK_EN
              misalign_err     <= misaligned;
`endif
            end
          end
        end

        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= WAIT;
          end
        end

        WAIT: begin
          // The output register is always empty here.
          // Accepting this instruction required it to be draining.
          if (rsp_valid) begin
            state            <= IDLE;
            mem_in_valid     <= 1'b1;
            wdata_gpr_W      <= pend_load ? load_data : pend_wdata_gpr;
            Gpr_Write_W      <= pend_gpr_write;
            Gpr_Write_Addr_W <= pend_gpr_addr;
            Csr_Write_W      <= pend_csr_write;
            Csr_Write_Addr_W <= pend_csr_addr;
            wdata_csr_W      <= pend_wdata_csr;
`ifdef YSYX_24100006_LSU_MISALIGN_CHK_EN
            misalign_err     <= 1'b0;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: ysyx_24100006_lsu

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-low reset; single clock domain, all state on rising clk.
REQ-002 SHALL have upstream ports: mem_out_valid  in  1  EXE_MEM valid; mem_out_ready  out  1  LSU accepts.
REQ-003 SHALL have downstream ports: mem_in_valid  out  1  result valid to MEM_WB; mem_in_ready  in  1  MEM_WB accepts.
REQ-004 SHALL have ports: alu_result  in  32  address or ALU result; store_data_M  in  32  rs2 data; wdata_gpr_M  in  32  non-load writeback data.
REQ-005 SHALL have ports: sram_read_write_M  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none); Mem_Mask_M  in  3  funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-006 SHALL have ports: Gpr_Write_M  in  1; Gpr_Write_Addr_M  in  4; Csr_Write_M  in  1; Csr_Write_Addr_M  in  12; wdata_csr_M  in  32; each with a registered _W output of the same width.
REQ-007 SHALL have bus ports: req_valid  out  1; req_ready  in  1; req_wen  out  1; req_addr  out  32; req_wdata  out  32; req_wstrb  out  4; rsp_valid  in  1; rsp_rdata  in  32.
REQ-008 SHALL have ports: wdata_gpr_W  out  32  final GPR data; mem_busy  out  1  state != IDLE; mem_fw_data  out  32  equals wdata_gpr_W.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT: IDLE->REQ on accepted load/store; REQ->WAIT on req_valid&&req_ready; WAIT->IDLE on rsp_valid.
REQ-010 SHALL assert mem_out_ready = (state==IDLE) && (!mem_in_valid || mem_in_ready).
REQ-011 On an accepted non-memory op, SHALL load the output register next edge: mem_in_valid=1, wdata_gpr_W=wdata_gpr_M, control fields passed through (latency 1).
REQ-012 On an accepted memory op, SHALL latch address, data, mask, and control, enter REQ, and drive req_valid=1 from the next cycle, holding all req_* stable until req_ready.
REQ-013 SHALL drive req_addr={addr[31:2],2'b00}; store wstrb: b 4'b0001<<addr[1:0], h 4'b0011<<addr[1:0], w 4'b1111; req_wdata = store data replicated into the selected lanes; loads use req_wen=0, wstrb=0.
REQ-014 On rsp_valid in WAIT, SHALL extract the byte or halfword at addr[1:0], sign-extend (b, h) or zero-extend (bu, hu), and write wdata_gpr_W; stores keep wdata_gpr_M; mem_in_valid=1 the next cycle.
REQ-015 SHALL hold mem_in_valid and all _W outputs stable until mem_in_ready; a same-cycle drain and new accept SHALL both occur.
REQ-016 SHALL ignore rsp_valid outside WAIT; the slave never responds in the same cycle as the request handshake.
REQ-017 SHALL treat Mem_Mask 011, 110, and 111 as word accesses.

Reset
REQ-018 While reset==0 at a clock edge: state=IDLE, mem_in_valid=0, req_valid=0, and all data/control outputs =0.
REQ-019 A reset during REQ or WAIT SHALL abandon the transaction without a writeback; a late rsp_valid SHALL be ignored.

Configuration
REQ-020 Macro YSYX_24100006_LSU_MISALIGN_CHK_EN: when defined, a halfword at addr[0]=1 or a word at addr[1:0]!=0 SHALL skip the bus (no req_valid), complete in 1 cycle with Gpr_Write_W=0, and pulse output misalign_err  out  1 with mem_in_valid.
REQ-021 When the macro is undefined, the misalign_err port SHALL be absent, and misaligned accesses SHALL issue using the truncated lane mapping of REQ-013.

Verification
REQ-022 Non-mem: wdata_gpr_M=0x1234, Gpr_Write_Addr_M=5, mem_in_ready=1 -> next cycle mem_in_valid=1, wdata_gpr_W=0x1234, Gpr_Write_Addr_W=5, req_valid never asserted.
REQ-023 lb at addr 0x80000003, rsp_rdata=0x80FF_FF7F, req_ready delayed 2 cycles -> req_addr=0x80000000, wdata_gpr_W=0xFFFF_FF80.
REQ-024 sh at addr 0x80000002, store_data_M=0xAAAA_BEEF -> req_wen=1, req_wstrb=4'b1100, req_wdata[31:16]=0xBEEF; writeback after rsp_valid.
REQ-025 Backpressure: mem_in_ready=0 for 3 cycles after a load completes -> outputs stable, mem_out_ready=0; on release, drain and a new accept occur in the same cycle.
REQ-026 Reset asserted in WAIT, then rsp_valid after release -> no mem_in_valid pulse; state IDLE.
REQ-027 With MISALIGN_CHK_EN defined, lw at 0x80000001 -> no req_valid; misalign_err=1 with mem_in_valid; Gpr_Write_W=0.
